// File: rtl/mfp_ahb_load_arbiter_if.sv
// Signal bundle for the load arbiter: loader byte stream, CPU master side and shared slave side.
interface mfp_ahb_load_arbiter_if;
    logic        load_active;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        wr_ready;

    logic [31:0] c_HADDR;
    logic [2:0]  c_HBURST;
    logic        c_HMASTLOCK;
    logic [3:0]  c_HPROT;
    logic [2:0]  c_HSIZE;
    logic [1:0]  c_HTRANS;
    logic [31:0] c_HWDATA;
    logic        c_HWRITE;
    logic        c_HREADY;
    logic [31:0] c_HRDATA;
    logic        c_HRESP;

    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    logic        cpu_hold;
    logic        load_error;

    modport slave (
        input  load_active, wr_valid, wr_addr, wr_byte,
        input  c_HADDR, c_HBURST, c_HMASTLOCK, c_HPROT, c_HSIZE, c_HTRANS, c_HWDATA, c_HWRITE,
        input  HREADY, HRDATA, HRESP,
        output wr_ready, c_HREADY, c_HRDATA, c_HRESP,
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output cpu_hold, load_error
    );

    modport master (
        output load_active, wr_valid, wr_addr, wr_byte,
        output c_HADDR, c_HBURST, c_HMASTLOCK, c_HPROT, c_HSIZE, c_HTRANS, c_HWDATA, c_HWRITE,
        output HREADY, HRDATA, HRESP,
        input  wr_ready, c_HREADY, c_HRDATA, c_HRESP,
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  cpu_hold, load_error
    );
endinterface

// File: rtl/mfp_ahb_load_arbiter.sv
// Shares one AHB-Lite slave port between the CPU and the SREC loader byte stream; holds the CPU
// in reset while loading. Loader bytes reach the bus one cycle after queueing; wr_ready = !full.
module mfp_ahb_load_arbiter #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mfp_ahb_load_arbiter_if.slave bus
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = $clog2(RELEASE_CYCLES + 1);
    localparam logic [AW:0] CNT_FULL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0]  HTRANS_IDLE = 2'b00;
    localparam logic [1:0]  HTRANS_NSEQ = 2'b10;

    typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_dat  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          full, empty, push, pop;
    logic          dp_pend;
    logic [7:0]    dp_byte;
    logic [CW-1:0] guard_cnt, guard_nxt;
    logic          cpu_hold_q, load_error_q;

    assign empty     = (count == '0);
    assign push      = bus.wr_valid && !full;
    assign pop       = (state == LOAD) && !empty && bus.HREADY;
    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign bus.wr_ready   = !full;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_error = load_error_q;
    assign bus.c_HRDATA   = bus.HRDATA;
    assign bus.c_HRESP    = bus.HRESP;

    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        case (state)
            RUN: begin
                if (bus.load_active && bus.HREADY)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (!bus.load_active && empty && (!dp_pend || bus.HREADY)) begin
                    state_nxt = RELEASE;
                    guard_nxt = CW'(RELEASE_CYCLES - 1);
                end
            end
            RELEASE: begin
                if (bus.load_active)
                    state_nxt = LOAD;
                else if (guard_cnt == '0)
                    state_nxt = RUN;
                else
                    guard_nxt = guard_cnt - CW'(1);
            end
            default: state_nxt = RUN;
        endcase
    end

    // Outside RUN the loader owns the bus; idle cycles still present the queue head.
    always_comb begin
        bus.HADDR     = fifo_addr[rd_ptr];
        bus.HBURST    = 3'b000;
        bus.HMASTLOCK = 1'b0;
        bus.HPROT     = 4'b0011;
        bus.HSIZE     = 3'b000;
        bus.HTRANS    = HTRANS_IDLE;
        bus.HWDATA    = {4{dp_byte}};
        bus.HWRITE    = 1'b1;
        bus.c_HREADY  = 1'b1;
        if (state == RUN) begin
            bus.HADDR     = bus.c_HADDR;
            bus.HBURST    = bus.c_HBURST;
            bus.HMASTLOCK = bus.c_HMASTLOCK;
            bus.HPROT     = bus.c_HPROT;
            bus.HSIZE     = bus.c_HSIZE;
            bus.HTRANS    = bus.load_active ? HTRANS_IDLE : bus.c_HTRANS;
            bus.HWDATA    = bus.c_HWDATA;
            bus.HWRITE    = bus.c_HWRITE;
            bus.c_HREADY  = bus.HREADY;
        end else if (state == LOAD && !empty) begin
            bus.HTRANS = HTRANS_NSEQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            dp_pend      <= 1'b0;
            dp_byte      <= '0;
            guard_cnt    <= '0;
            cpu_hold_q   <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            guard_cnt  <= guard_nxt;
            cpu_hold_q <= (state_nxt != RUN);
            count      <= count_nxt;
            full       <= (count_nxt == CNT_FULL);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (bus.HREADY) begin
                dp_pend <= pop;
                if (pop)
                    dp_byte <= fifo_dat[rd_ptr];
            end
            if (state == RUN && state_nxt == LOAD)
                load_error_q <= 1'b0;
            else if (dp_pend && bus.HREADY && bus.HRESP)
                load_error_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_dat[wr_ptr]  <= bus.wr_byte;
        end
    end
endmodule

// File: tb/tb_mfp_ahb_load_arbiter.sv
// Scoreboard bench: accepted loader bytes are queued and matched against loader bus writes.
module tb_mfp_ahb_load_arbiter;
    localparam int RELEASE_CYCLES = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mfp_ahb_load_arbiter_if bus();

    mfp_ahb_load_arbiter #(.FIFO_DEPTH(4), .RELEASE_CYCLES(RELEASE_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;

    int          hr_mode;   // 0 always ready, 1 manual, 2 two wait states of every three
    logic        hr_manual;
    logic        err_en;
    logic [31:0] err_addr;

    logic [39:0] sb_q[$];
    logic        mon_dp = 1'b0;
    logic [7:0]  mon_byte;
    logic [31:0] mon_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: drives HREADY/HRESP shortly after each edge.
    initial begin
        int cyc = 0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h5A5A_0001;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (hr_mode)
                1:       bus.HREADY = hr_manual;
                2:       bus.HREADY = (cyc % 3 == 0);
                default: bus.HREADY = 1'b1;
            endcase
            bus.HRESP = err_en && mon_dp && (mon_addr == err_addr);
        end
    end

    // Monitor: queue accepted bytes, check each loader address and data phase.
    always @(negedge clk) begin
        logic [39:0] e;
        if (rst) begin
            sb_q.delete();
            mon_dp = 1'b0;
        end else begin
            if (bus.wr_valid && bus.wr_ready)
                sb_q.push_back({bus.wr_addr, bus.wr_byte});
            if (bus.cpu_hold && bus.HREADY) begin
                if (mon_dp) begin
                    chk("hwdata", bus.HWDATA, {4{mon_byte}});
                    n_wr++;
                end
                mon_dp = 1'b0;
                if (bus.HTRANS == 2'b10) begin
                    chk("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("haddr", bus.HADDR, e[39:8]);
                        chk("hwrite_hsize", {bus.HWRITE, bus.HSIZE}, 4'b1000);
                        mon_dp   = 1'b1;
                        mon_byte = e[7:0];
                        mon_addr = e[39:8];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [31:0] a, input logic [7:0] d);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_byte  = d;
        @(negedge clk);
        while (!bus.wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || mon_dp) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, n < 1000, 1);
        tick();
    endtask

    task automatic wait_hold(input logic v, input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.cpu_hold !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.cpu_hold, v);
        tick();
    endtask

    initial begin
        int base, cnt, lows;
        rst = 1'b1;
        bus.load_active = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_byte     = '0;
        bus.c_HADDR     = 32'h0000_1234;
        bus.c_HBURST    = 3'b000;
        bus.c_HMASTLOCK = 1'b0;
        bus.c_HPROT     = 4'b0011;
        bus.c_HSIZE     = 3'b010;
        bus.c_HTRANS    = 2'b10;
        bus.c_HWDATA    = 32'hCAFE_F00D;
        bus.c_HWRITE    = 1'b1;
        hr_mode = 0; hr_manual = 1'b1; err_en = 1'b0; err_addr = '0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_cpu_hold", bus.cpu_hold, 0);
        chk("rst_load_error", bus.load_error, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("run_htrans", bus.HTRANS, 2'b10);
        chk("run_haddr", bus.HADDR, 32'h0000_1234);
        chk("run_hwdata", bus.HWDATA, 32'hCAFE_F00D);
        chk("run_c_hready", bus.c_HREADY, 1);
        chk("run_c_hrdata", bus.c_HRDATA, 32'h5A5A_0001);
        tick();

        // Entry drain: CPU data phase waited 3 cycles while load_active is up
        hr_mode = 1; hr_manual = 1'b0;
        bus.load_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_htrans_idle", bus.HTRANS, 2'b00);
            chk("drain_c_hready", bus.c_HREADY, 0);
            chk("drain_cpu_hold", bus.cpu_hold, 0);
            tick();
        end
        hr_manual = 1'b1;
        @(negedge clk);
        chk("drain_hold_decision", bus.cpu_hold, 0);
        tick();
        @(negedge clk);
        chk("load_cpu_hold", bus.cpu_hold, 1);
        chk("load_c_hready", bus.c_HREADY, 1);
        tick();

        // Stream: fill the queue with the slave stalled, then drain at full rate
        hr_manual = 1'b0;
        base = n_wr;
        for (int i = 0; i < 4; i++) push_byte(32'h0000_1000 + i, 8'h10 + 8'(i));
        @(negedge clk);
        chk("full_wr_ready", bus.wr_ready, 0);
        tick();
        hr_mode = 0;
        for (int i = 4; i < 8; i++) push_byte(32'h0000_1000 + i, 8'h10 + 8'(i));
        wait_drain("stream");
        chk("stream_count", n_wr - base, 8);

        // First-byte latency: address phase the cycle after the push edge
        push_byte(32'h0000_1100, 8'h77);
        @(negedge clk);
        chk("lat_htrans", bus.HTRANS, 2'b10);
        chk("lat_haddr", bus.HADDR, 32'h0000_1100);
        tick();
        wait_drain("lat");

        // Backpressure: two wait states per transfer
        hr_mode = 2;
        base = n_wr;
        for (int i = 0; i < 6; i++) push_byte(32'h0000_2000 + i, 8'hA0 + 8'(i));
        wait_drain("bp");
        chk("bp_count", n_wr - base, 6);
        hr_mode = 0;

        // Release guard length
        bus.load_active = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (bus.cpu_hold && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("release_len", cnt, RELEASE_CYCLES + 1);
        chk("back_run_htrans", bus.HTRANS, 2'b10);
        chk("back_run_hwdata", bus.HWDATA, 32'hCAFE_F00D);
        tick();

        // Reassert during guard interval
        bus.load_active = 1'b1;
        wait_hold(1'b1, "reenter_hold");
        push_byte(32'h0000_3100, 8'h31);
        wait_drain("reenter");
        bus.load_active = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.load_active = 1'b1;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.cpu_hold) lows++;
        end
        chk("guard_abort_hold", lows, 0);
        tick();
        base = n_wr;
        push_byte(32'h0000_3200, 8'h32);
        wait_drain("guard_abort");
        chk("guard_abort_wr", n_wr - base, 1);

        // Error on second byte
        chk("err_initial", bus.load_error, 0);
        err_en = 1'b1; err_addr = 32'h0000_3001;
        for (int i = 0; i < 3; i++) push_byte(32'h0000_3000 + i, 8'hE0 + 8'(i));
        wait_drain("err");
        err_en = 1'b0;
        chk("err_set", bus.load_error, 1);
        bus.load_active = 1'b0;
        wait_hold(1'b0, "err_release");
        chk("err_sticky_run", bus.load_error, 1);
        bus.load_active = 1'b1;
        wait_hold(1'b1, "err_reload");
        chk("err_cleared", bus.load_error, 0);

        // Reset mid-load with bytes queued
        hr_mode = 1; hr_manual = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(32'h0000_5000 + i, 8'h50 + 8'(i));
        rst = 1'b1;
        bus.load_active = 1'b0;
        @(negedge clk);
        chk("mid_rst_cpu_hold", bus.cpu_hold, 0);
        chk("mid_rst_wr_ready", bus.wr_ready, 1);
        tick();
        rst = 1'b0;
        hr_mode = 0;
        @(negedge clk);
        chk("post_rst_htrans", bus.HTRANS, 2'b10);
        tick();
        bus.load_active = 1'b1;
        wait_hold(1'b1, "post_rst_load");
        base = n_wr;
        push_byte(32'h0000_6000, 8'h66);
        wait_drain("post_rst");
        chk("post_rst_wr", n_wr - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
